// File: rtl/elevator_pkg.sv
// Shared encodings and helpers for the 4-floor elevator car controller.
// The request code, state constants and the SCAN look-ahead function live here.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int REQ_VALID  = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MOVE = 2'd1;
  localparam logic [1:0] ST_DOOR = 2'd2;

  localparam logic [1:0] FLOOR_BOTTOM = 2'd0;
  localparam logic [1:0] FLOOR_TOP    = 2'd3;

  // True when some pending floor lies strictly beyond 'floor' in direction 'dir_up'.
  function automatic logic ahead(input logic [NUM_FLOORS-1:0] mask,
                                 input logic [1:0]            floor,
                                 input logic                  dir_up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (mask[i] && (dir_up ? (i > int'(floor)) : (i < int'(floor))))
        hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/elevator_car_ctrl_tick_timer.sv
// Up-counter with synchronous clear and a terminal-count flag; the car
// controller shares one instance between floor travel and door hold.
module tick_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr)
      count_reg <= '0;
    else if (en)
      count_reg <= count_reg + WIDTH'(1);
  end

  assign done = en && (count_reg == last);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: latches floor calls into a pending mask and runs
// a SCAN-style IDLE/MOVE/DOOR sequence over four floors.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int FLOOR_TICKS = 50_000_000,
  parameter int DOOR_TICKS  = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] n_stage,
  output logic [1:0] cur_floor,
  output logic       dir_up,
  output logic       moving,
  output logic       door_open,
  output logic       arrived,
  output logic [3:0] pending
);

  localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW        = $clog2(MAX_TICKS);
  localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_TICKS - 1);

  logic [1:0]            state_reg, state_next;
  logic [1:0]            floor_reg, floor_next;
  logic                  dir_reg, dir_next, dir_pick;
  logic [NUM_FLOORS-1:0] pending_reg, pending_next;
  logic                  arrived_reg, arrived_next;
  logic                  moving_reg, door_reg;

  logic                  req_valid, here_req;
  logic [1:0]            req_floor, step_floor;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask;
  logic                  timer_clr, timer_en, timer_done;
  logic [TW-1:0]         timer_last;

  assign req_valid  = n_stage[REQ_VALID];
  assign req_floor  = n_stage[1:0];
  // A call for the floor the car is standing at opens (or re-opens) the door instead of latching.
  assign here_req   = req_valid && (req_floor == floor_reg) && (state_reg != ST_MOVE);
  assign step_floor = dir_reg ? floor_reg + 2'd1 : floor_reg - 2'd1;

  generate
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_set
      assign set_mask[gi] = req_valid && !here_req && (req_floor == 2'(gi));
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    floor_next   = floor_reg;
    dir_pick     = dir_reg;
    arrived_next = 1'b0;
    clr_mask     = '0;
    timer_clr    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        timer_clr = 1'b1;
        if (here_req) begin
          state_next   = ST_DOOR;
          arrived_next = 1'b1;
        end else if (pending_reg[floor_reg]) begin
          clr_mask[floor_reg] = 1'b1;
          state_next          = ST_DOOR;
          arrived_next        = 1'b1;
        end else if (pending_reg != '0) begin
          dir_pick   = ahead(pending_reg, floor_reg, dir_reg) ? dir_reg : ~dir_reg;
          state_next = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (timer_done) begin
          timer_clr  = 1'b1;
          floor_next = step_floor;
          if (pending_reg[step_floor]) begin
            clr_mask[step_floor] = 1'b1;
            state_next           = ST_DOOR;
            arrived_next         = 1'b1;
          end else if (pending_reg == '0) begin
            state_next = ST_IDLE;
          end else begin
            dir_pick = ahead(pending_reg, step_floor, dir_reg) ? dir_reg : ~dir_reg;
          end
        end
      end
      ST_DOOR: begin
        if (here_req) begin
          timer_clr = 1'b1;
        end else if (timer_done) begin
          timer_clr  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        timer_clr  = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  // End floors pin the direction so the car never points out of the shaft.
  assign dir_next     = (floor_next == FLOOR_TOP)    ? 1'b0 :
                        (floor_next == FLOOR_BOTTOM) ? 1'b1 : dir_pick;
  assign pending_next = (pending_reg | set_mask) & ~clr_mask;
  assign timer_en     = (state_reg == ST_MOVE) || (state_reg == ST_DOOR);
  assign timer_last   = (state_reg == ST_MOVE) ? FLOOR_LAST : DOOR_LAST;

  tick_timer #(.WIDTH(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .en   (timer_en),
    .last (timer_last),
    .done (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      floor_reg   <= FLOOR_BOTTOM;
      dir_reg     <= 1'b1;
      pending_reg <= '0;
      arrived_reg <= 1'b0;
      moving_reg  <= 1'b0;
      door_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      floor_reg   <= floor_next;
      dir_reg     <= dir_next;
      pending_reg <= pending_next;
      arrived_reg <= arrived_next;
      moving_reg  <= (state_next == ST_MOVE);
      door_reg    <= (state_next == ST_DOOR);
    end
  end

  assign cur_floor = floor_reg;
  assign dir_up    = dir_reg;
  assign moving    = moving_reg;
  assign door_open = door_reg;
  assign arrived   = arrived_reg;
  assign pending   = pending_reg;

endmodule
